// File: rtl/ccd_frame_loader.sv
// ccd_frame_loader
// ----------------
// Sequences one grayscale image capture per CPU request and loads it into DMEM.
// After a CPU request it pulses the capture start and waits for the start of
// a whole frame. It then packs NPIX 12-bit pixels, sixteen per word, into
// 256-bit words and writes each word to DMEM as soon as it is complete.
// Completion is reported with a level oDONE that holds until the request drops.
//
// Parameters
//   BASE_ADDR  DMEM word address of pixel word 0 (BASE_ADDR + NPIX/16 - 1 <= 127)
//   NPIX       pixels per image, multiple of 16 (at most 1024 for the 10-bit counter)
//
// Ports
//   iCLK      single clock for pixel stream, CPU and DMEM
//   iRST      synchronous active-high reset
//   iENABLE   CPU capture request (level); dropping it aborts or acknowledges
//   iFVAL     frame valid from the capture stage
//   iDVAL     pixel valid for iDATA
//   iDATA     12-bit gray pixel
//   oSTART    one-cycle start pulse to the capture stage
//   oBUSY     high while arming or capturing
//   oDONE     image fully written (level)
//   oERR      one-cycle pulse when a frame ended short
//   oWREN     DMEM write enable (one cycle per word)
//   oWRADDR   DMEM word address, held between writes
//   oWRDATA   DMEM write data, held between writes
module ccd_frame_loader #(
  parameter int BASE_ADDR = 0,
  parameter int NPIX      = 784
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iENABLE,
  input  logic         iFVAL,
  input  logic         iDVAL,
  input  logic [11:0]  iDATA,
  output logic         oSTART,
  output logic         oBUSY,
  output logic         oDONE,
  output logic         oERR,
  output logic         oWREN,
  output logic [6:0]   oWRADDR,
  output logic [255:0] oWRDATA
);

  localparam int         NWORDS    = NPIX / 16;
  localparam logic [9:0] LAST_PIX  = 10'(NPIX - 1);
  localparam logic [5:0] LAST_WORD = 6'(NWORDS - 1);
  localparam logic [6:0] BASE      = 7'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state_reg, state_next;

  logic           fval_q;
  logic [9:0]     pix_cnt_reg;
  logic [5:0]     word_cnt_reg;
  logic           full_reg;       // last pixel taken; one more CAPTURE cycle while it is written
  logic [255:0]   pack_reg;
  logic [255:0]   pack_next;
  logic           start_reg;
  logic           err_reg;
  logic           wren_reg;
  logic [6:0]     wraddr_reg;
  logic [255:0]   wrdata_reg;

  logic           fval_rise;
  logic           fval_fall;
  logic           word_end;
  logic           last_pix;
  logic           accept;
  logic           start_next;
  logic           err_next;
  logic           wren_next;

  assign fval_rise = iFVAL & ~fval_q;
  assign fval_fall = ~iFVAL & fval_q;
  assign word_end  = (pix_cnt_reg[3:0] == 4'hF);
  assign last_pix  = (pix_cnt_reg == LAST_PIX);

  // ---------------------------------------------------------------------------
  // Next-state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    start_next = 1'b0;
    err_next   = 1'b0;
    wren_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (iENABLE) begin
          start_next = 1'b1;
          state_next = ARM;
        end
      end

      ARM: begin
        // iDVAL is deliberately ignored here, including the edge cycle.
        if (!iENABLE) begin
          state_next = IDLE;
        end else if (fval_rise) begin
          state_next = CAPTURE;
        end
      end

      CAPTURE: begin
        if (!iENABLE) begin
          // Abort: nothing new is accepted or written.
          state_next = IDLE;
        end else if (full_reg) begin
          // The final word is on the DMEM bus this cycle; report next cycle.
          state_next = DONE;
        end else begin
          accept    = iDVAL;
          wren_next = iDVAL & word_end;
          // A pixel arriving with the falling edge counts before the check,
          // so a frame whose last pixel coincides with the fall is complete.
          if (fval_fall && !(iDVAL && last_pix)) begin
            err_next   = 1'b1;
            state_next = ARM;
          end
        end
      end

      DONE: begin
        if (!iENABLE) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pack register lanes: the accepted pixel replaces its lane, others hold.
  // The write data is taken from pack_next so the word includes lane 15.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      assign pack_next[16*gi +: 16] =
        (accept && (pix_cnt_reg[3:0] == 4'(gi))) ? {4'b0000, iDATA}
                                                  : pack_reg[16*gi +: 16];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fval_q       <= 1'b0;
      pix_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      full_reg     <= 1'b0;
      pack_reg     <= '0;
      start_reg    <= 1'b0;
      err_reg      <= 1'b0;
      wren_reg     <= 1'b0;
      wraddr_reg   <= '0;
      wrdata_reg   <= '0;
    end else begin
      fval_q    <= iFVAL;
      start_reg <= start_next;
      err_reg   <= err_next;
      wren_reg  <= wren_next;

      if (wren_next) begin
        wraddr_reg <= BASE + {1'b0, word_cnt_reg};
        wrdata_reg <= pack_next;
      end

      // Lanes are always overwritten before reuse, so no clear is needed.
      if (accept) begin
        pack_reg <= pack_next;
      end

      // Counters only live inside CAPTURE; any exit (done, abort, short
      // frame) restarts them from zero.
      if (state_next != CAPTURE) begin
        pix_cnt_reg  <= '0;
        word_cnt_reg <= '0;
        full_reg     <= 1'b0;
      end else if (accept) begin
        if (last_pix) begin
          full_reg <= 1'b1;
        end else begin
          pix_cnt_reg <= pix_cnt_reg + 10'd1;
        end
        if (word_end && (word_cnt_reg != LAST_WORD)) begin
          word_cnt_reg <= word_cnt_reg + 6'd1;
        end
      end
    end
  end

  assign oSTART  = start_reg;
  assign oBUSY   = (state_reg == ARM) || (state_reg == CAPTURE);
  assign oDONE   = (state_reg == DONE);
  assign oERR    = err_reg;
  assign oWREN   = wren_reg;
  assign oWRADDR = wraddr_reg;
  assign oWRDATA = wrdata_reg;

endmodule

// File: tb/tb_ccd_frame_loader.sv
// Testbench for ccd_frame_loader. Two instances (BASE_ADDR 0 and 64) see the
// same stimulus; each has its own write scoreboard fed by the stimulus and
// drained by a monitor on oWREN. Control outputs are checked inline.
module tb_ccd_frame_loader;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         fval;
  logic         dval;
  logic [11:0]  data;

  logic         start0, busy0, done0, err0, wren0;
  logic [6:0]   wraddr0;
  logic [255:0] wrdata0;
  logic         start1, busy1, done1, err1, wren1;
  logic [6:0]   wraddr1;
  logic [255:0] wrdata1;

  int n_vec = 0;
  int n_bad = 0;

  logic [262:0] q0[$];
  logic [262:0] q1[$];
  logic [255:0] exp_word = '0;

  ccd_frame_loader #(.BASE_ADDR(0), .NPIX(784)) dut0 (
    .iCLK(clk), .iRST(rst), .iENABLE(enable), .iFVAL(fval), .iDVAL(dval), .iDATA(data),
    .oSTART(start0), .oBUSY(busy0), .oDONE(done0), .oERR(err0),
    .oWREN(wren0), .oWRADDR(wraddr0), .oWRDATA(wrdata0)
  );

  ccd_frame_loader #(.BASE_ADDR(64), .NPIX(784)) dut1 (
    .iCLK(clk), .iRST(rst), .iENABLE(enable), .iFVAL(fval), .iDVAL(dval), .iDATA(data),
    .oSTART(start1), .oBUSY(busy1), .oDONE(done1), .oERR(err1),
    .oWREN(wren1), .oWRADDR(wraddr1), .oWRDATA(wrdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (wren0 === 1'b1) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL wr0_unexpected got addr=%0d data=%h required no write", wraddr0, wrdata0);
      end else begin
        logic [262:0] e;
        e = q0.pop_front();
        if ({wraddr0, wrdata0} !== e) begin
          n_bad++;
          $display("FAIL wr0 got addr=%0d data=%h required addr=%0d data=%h",
                   wraddr0, wrdata0, e[262:256], e[255:0]);
        end else begin
          $display("wr0 addr=%0d ok", wraddr0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (wren1 === 1'b1) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL wr1_unexpected got addr=%0d data=%h required no write", wraddr1, wrdata1);
      end else begin
        logic [262:0] e;
        e = q1.pop_front();
        if ({wraddr1, wrdata1} !== e) begin
          n_bad++;
          $display("FAIL wr1 got addr=%0d data=%h required addr=%0d data=%h",
                   wraddr1, wrdata1, e[262:256], e[255:0]);
        end else begin
          $display("wr1 addr=%0d ok", wraddr1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [263:0] got, input logic [263:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end else begin
      $display("%s ok", nm);
    end
  endtask

  // Expected {start, busy, done, err} for both instances.
  task automatic ctl(input string nm, input logic [3:0] e);
    chk({nm, "_d0"}, 264'({start0, busy0, done0, err0}), 264'(e));
    chk({nm, "_d1"}, 264'({start1, busy1, done1, err1}), 264'(e));
  endtask

  task automatic push(input int w);
    q0.push_back({7'(w), exp_word});
    q1.push_back({7'(64 + w), exp_word});
  endtask

  // Present pixel k for one cycle; when expected, model its lane and push
  // the finished word on lane 15.
  task automatic pix(input int k, input logic [11:0] d, input bit expect_it);
    dval = 1'b1;
    data = d;
    if (expect_it) begin
      exp_word[16*(k%16) +: 16] = {4'h0, d};
      if (k % 16 == 15) push(k / 16);
    end
    cycle();
  endtask

  task automatic frame(input int n, input int seed, input bit expect_it, input int gap);
    for (int k = 0; k < n; k++) begin
      if (gap > 0 && k > 0 && (k % gap) == gap - 1) begin
        dval = 1'b0;
        cycle();
      end
      pix(k, 12'((k * seed) % 4096), expect_it);
    end
    dval = 1'b0;
  endtask

  task automatic arm(input string nm);
    enable = 1'b1;
    cycle();
    ctl({nm, "_start"}, 4'b1100);
  endtask

  // Rising iFVAL with a junk pixel that must be ignored in the edge cycle.
  task automatic rise(input string nm);
    fval = 1'b1;
    dval = 1'b1;
    data = 12'hABC;
    cycle();
    dval = 1'b0;
    ctl({nm, "_capture"}, 4'b0100);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1; enable = 1'b0; fval = 1'b0; dval = 1'b0; data = '0;
    cycle();
    cycle();
    ctl("reset", 4'b0000);
    chk("reset_wr0", 264'({wren0, wraddr0, wrdata0}), 264'(0));
    chk("reset_wr1", 264'({wren1, wraddr1, wrdata1}), 264'(0));
    rst = 1'b0;
    cycle();
    ctl("idle", 4'b0000);

    // Normal capture, pixel value = k, occasional gaps in iDVAL.
    arm("t1");
    rise("t1");
    frame(784, 1, 1'b1, 7);
    ctl("t1_writecyc", 4'b0100);
    cycle();
    ctl("t1_done", 4'b0010);
    for (int i = 0; i < 3; i++) pix(900 + i, 12'h555, 1'b0);
    dval = 1'b0;
    fval = 1'b0;
    cycle();
    ctl("t1_done_hold", 4'b0010);
    enable = 1'b0;
    cycle();
    ctl("t1_release", 4'b0000);

    // Armed mid-frame, then a short frame, then a full retry.
    fval = 1'b1;
    cycle();
    arm("t2");
    frame(100, 3, 1'b0, 0);
    fval = 1'b0;
    cycle();
    ctl("t2_partial_fall", 4'b0100);
    cycle();
    rise("t2a");
    frame(500, 5, 1'b1, 0);
    fval = 1'b0;
    cycle();
    ctl("t2_err", 4'b0101);
    cycle();
    ctl("t2_rearm", 4'b0100);
    rise("t2b");
    frame(784, 11, 1'b1, 0);
    cycle();
    ctl("t2_done", 4'b0010);
    fval = 1'b0;
    enable = 1'b0;
    cycle();
    ctl("t2_release", 4'b0000);

    // Abort after 200 pixels; pixels keep coming but nothing is written.
    arm("t3");
    rise("t3");
    frame(200, 13, 1'b1, 0);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pix(200 + i, 12'(i), 1'b0);
      if (i == 0) ctl("t3_abort", 4'b0000);
    end
    dval = 1'b0;
    fval = 1'b0;
    cycle();
    ctl("t3_quiet", 4'b0000);

    // Back-to-back pixels, last pixel coincident with the iFVAL fall.
    arm("t4");
    rise("t4");
    frame(783, 17, 1'b1, 0);
    fval = 1'b0;
    pix(783, 12'((783 * 17) % 4096), 1'b1);
    dval = 1'b0;
    ctl("t4_noerr", 4'b0100);
    cycle();
    ctl("t4_done", 4'b0010);
    enable = 1'b0;
    cycle();
    ctl("t4_release", 4'b0000);

    // Reset mid-capture, with a word-completing pixel in the reset cycle.
    arm("t5");
    rise("t5");
    frame(31, 19, 1'b1, 0);
    rst = 1'b1;
    pix(31, 12'h7FF, 1'b0);
    dval = 1'b0;
    ctl("t5_rst", 4'b0000);
    chk("t5_rst_wr0", 264'({wren0, wraddr0, wrdata0}), 264'(0));
    chk("t5_rst_wr1", 264'({wren1, wraddr1, wrdata1}), 264'(0));
    rst = 1'b0;
    fval = 1'b0;
    cycle();
    ctl("t5_idle_restart", 4'b1100);
    enable = 1'b0;
    cycle();
    ctl("t5_release", 4'b0000);

    for (int i = 0; i < 4; i++) cycle();
    chk("q0_drained", 264'(q0.size()), 264'(0));
    chk("q1_drained", 264'(q1.size()), 264'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ccd_frame_loader.md
# ccd_frame_loader

Controller that sequences one 28x28 grayscale capture per CPU request and loads it into data memory. Sits between the CPU/DMEM interface and the downsampled pixel stream at the end of the image capture pipeline (capture → raw-to-gray → crop-down). It pulses the capture start, aligns to the next full frame, packs 784 pixels into 49 256-bit words, writes them to DMEM and signals completion back to the CPU.

## Interface
- BASE_ADDR, 0: DMEM word address of pixel word 0; BASE_ADDR+48 must be ≤ 127.
- NPIX, 784: pixels per image; must be a multiple of 16.
- iCLK  in  1  single clock; the pixel stream, CPU and DMEM signals are all synchronous to it.
- iRST  in  1  synchronous, active-high reset.
- iENABLE  in  1  CPU capture request (level).
- iFVAL  in  1  frame valid from the capture stage.
- iDVAL  in  1  downsampled pixel valid.
- iDATA  in  12  downsampled gray pixel.
- oSTART  out  1  one-cycle start pulse to the capture stage.
- oBUSY  out  1  high in ARM and CAPTURE.
- oDONE  out  1  image fully written; level.
- oERR  out  1  one-cycle pulse on a short frame.
- oWREN  out  1  DMEM write enable.
- oWRADDR  out  7  DMEM word address.
- oWRDATA  out  256  DMEM write data.

## Operation
- Reset: state IDLE; all outputs 0; pixel count, word count and pack register cleared; registered iFVAL (fval_q) cleared.
- States: IDLE, ARM, CAPTURE, DONE.
- IDLE: when iENABLE=1, assert oSTART for 1 cycle and go to ARM.
- ARM: oBUSY=1. Wait for a rising edge of iFVAL (iFVAL=1 and fval_q=0), then go to CAPTURE.
  - If iFVAL is already high on entry, wait for it to fall and rise again, so a partial frame is never captured.
  - iDVAL is ignored in ARM, including in the edge cycle itself.
- CAPTURE: oBUSY=1. Each cycle with iDVAL=1 accepts one pixel k (0..NPIX-1).
  - The pixel is stored as {4'b0, iDATA} in bits [16*(k%16)+15 : 16*(k%16)] of the pack register.
  - Lane 0 is the least-significant 16 bits.
  - On k%16 = 15, the completed word (including this pixel) is written to address BASE_ADDR + k/16.
- After pixel NPIX-1 is written, go to DONE. iDVAL is ignored from then on.
- Short frame: iFVAL falls (iFVAL=0, fval_q=1) in CAPTURE with fewer than NPIX pixels accepted:
  - pulse oERR;
  - discard the partial word (no write);
  - clear the counters;
  - return to ARM without re-pulsing oSTART.
  - Words already written are overwritten on the retry.
- If iDVAL=1 in the same cycle iFVAL falls, that pixel is accepted before the short-frame check. A short frame is declared only if the count is still below NPIX after that pixel.
- DONE: oDONE=1 and held until iENABLE=0, then go to IDLE. oDONE drops the same cycle the state returns to IDLE.
- Abort: iENABLE=0 in ARM or CAPTURE → IDLE next cycle.
  - No further writes; an oWREN already registered for that cycle still completes.
  - oDONE stays 0; oERR is not pulsed; counters are cleared.
- iRST mid-operation: immediate return to reset state on the next edge; any pending write is dropped.
- Pixel counter is 10 bits; word counter is 6 bits. Neither counter wraps: the maximum values are NPIX-1 and NPIX/16-1.

## Timing
- oSTART: high in the cycle after iENABLE is first seen high in IDLE; exactly 1 cycle wide.
- Write latency: a pixel accepted at edge t that completes a word → oWREN=1 with oWRADDR/oWRDATA valid during cycle t+1, for exactly 1 cycle.
- oWRADDR/oWRDATA hold their last values when oWREN=0.
- The pack register is not cleared between words; unused lanes are always overwritten before the next write.
- Back-to-back iDVAL every cycle is supported with no stall; the highest write rate is 1 word per 16 cycles.
- oDONE rises in the cycle after the final write cycle, i.e. final pixel accepted at t → write at t+1 → oDONE at t+2.
- oERR: asserted in the cycle after the iFVAL falling edge is sampled.
- No input or output handshake backpressure exists: DMEM accepts every write.

## Test plan
- **Normal capture:** iENABLE=1; iFVAL rises; 784 iDVAL pixels with value k%4096.
  - 49 writes at addresses 0..48.
  - Word 0 bits [15:0]=0x0000 and [255:240]=0x000F.
  - oDONE at final pixel +2.
  - oDONE clears 1 cycle after iENABLE=0.
- **Armed mid-frame:** iFVAL already high when iENABLE rises, with 100 pixels before iFVAL falls.
  - No writes from that frame.
  - Capture starts at the next iFVAL rise.
- **Short frame:** iFVAL falls after 500 pixels.
  - 31 writes (addresses 0..30).
  - oERR pulses once; FSM returns to ARM.
  - The next full frame rewrites addresses 0..48 and oDONE rises.
- **Abort:** iENABLE drops after 200 pixels.
  - Writes stop after address 11 (the word-12 write is not issued).
  - oBUSY=0 the next cycle; oDONE and oERR stay 0.
- **BASE_ADDR=64, back-to-back iDVAL:**
  - writes to 64..112 every 16 cycles;
  - final pixel coincident with the iFVAL fall → oDONE=1, no oERR.
- **iRST asserted mid-CAPTURE:** all outputs 0 the next cycle; the state is IDLE.
